// File: rtl/tnn_neuron_accum.sv
// Ternary neuron accumulator: sums clamped (pos - neg) popcounts per chunk,
// thresholds the total into a registered +1/0/-1. Option: TNN_ACC_SAT_EN.
module tnn_neuron_accum #(
    parameter int PC_W     = 5,
    parameter int PC_MAX   = 25,
    parameter int ACC_W    = 10,
    parameter int N_CHUNKS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PC_W-1:0]         pc_pos,
    input  logic [PC_W-1:0]         pc_neg,
    input  logic                    pc_last,
    input  logic                    pc_valid,
    output logic                    pc_ready,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic [1:0]              act,
    output logic signed [ACC_W-1:0] act_sum,
    output logic                    act_valid,
    input  logic                    act_ready,
    output logic                    err_chunk
);

    localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [PC_W-1:0]  PC_LIM   = PC_W'(PC_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CHUNKS - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    pc_ready_q;
    logic [1:0]              act_q;
    logic signed [ACC_W-1:0] act_sum_q;
    logic                    act_valid_q;
    logic                    err_q;

    logic [PC_W-1:0]         p_clamp;
    logic [PC_W-1:0]         n_clamp;
    logic signed [PC_W:0]    diff;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   diff_ext;
    logic signed [ACC_W:0]   sum_w;
    logic signed [ACC_W-1:0] acc_d;
    logic [1:0]              act_d;
    logic                    fire;
    logic                    at_max;
    logic                    close;

    always_comb begin
        p_clamp  = (pc_pos > PC_LIM) ? PC_LIM : pc_pos;
        n_clamp  = (pc_neg > PC_LIM) ? PC_LIM : pc_neg;
        diff     = $signed({1'b0, p_clamp}) - $signed({1'b0, n_clamp});
        acc_ext  = (ACC_W+1)'(acc_q);
        diff_ext = (ACC_W+1)'(diff);
        sum_w    = acc_ext + diff_ext;
`ifdef TNN_ACC_SAT_EN
        // one extra bit catches overflow; clip to the signed range
        if (sum_w[ACC_W] != sum_w[ACC_W-1])
            acc_d = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_d = sum_w[ACC_W-1:0];
`else
        acc_d = sum_w[ACC_W-1:0];
`endif
        if (acc_d >= thr_hi)
            act_d = 2'b01;
        else if (acc_d <= thr_lo)
            act_d = 2'b11;
        else
            act_d = 2'b00;
        fire   = pc_valid & pc_ready_q;
        at_max = (cnt_q == CNT_LAST);
        close  = fire & (pc_last | at_max);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            pc_ready_q  <= 1'b1;
            act_q       <= 2'b00;
            act_sum_q   <= '0;
            act_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (close) begin
                        act_q       <= act_d;
                        act_sum_q   <= acc_d;
                        act_valid_q <= 1'b1;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        pc_ready_q  <= 1'b0;
                        state_q     <= HOLD;
                        if (!pc_last)
                            err_q <= 1'b1;
                    end else if (fire) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (act_ready) begin
                        act_valid_q <= 1'b0;
                        pc_ready_q  <= 1'b1;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign pc_ready  = pc_ready_q;
    assign act       = act_q;
    assign act_sum   = act_sum_q;
    assign act_valid = act_valid_q;
    assign err_chunk = err_q;

endmodule

// File: tb/tb_tnn_neuron_accum.sv
// Directed bench for tnn_neuron_accum: single-beat vector table plus
// multi-beat, stall, force-close, reset and narrow-accumulator sequences.
module tb_tnn_neuron_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [4:0]        pc_pos, pc_neg;
    logic              pc_last, pc_valid, pc_ready;
    logic signed [9:0] thr_hi, thr_lo;
    logic [1:0]        act;
    logic signed [9:0] act_sum;
    logic              act_valid, act_ready, err_chunk;

    logic [4:0]        s_pos, s_neg;
    logic              s_last, s_valid, s_ready;
    logic signed [5:0] s_thr_hi, s_thr_lo;
    logic [1:0]        s_act;
    logic signed [5:0] s_sum;
    logic              s_act_valid, s_act_ready, s_err;

    tnn_neuron_accum dut (
        .clk(clk), .rst_n(rst_n),
        .pc_pos(pc_pos), .pc_neg(pc_neg),
        .pc_last(pc_last), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .act(act), .act_sum(act_sum),
        .act_valid(act_valid), .act_ready(act_ready),
        .err_chunk(err_chunk)
    );

    tnn_neuron_accum #(.ACC_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .pc_pos(s_pos), .pc_neg(s_neg),
        .pc_last(s_last), .pc_valid(s_valid), .pc_ready(s_ready),
        .thr_hi(s_thr_hi), .thr_lo(s_thr_lo),
        .act(s_act), .act_sum(s_sum),
        .act_valid(s_act_valid), .act_ready(s_act_ready),
        .err_chunk(s_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0] pos;
        logic [4:0] neg;
        int         hi;
        int         lo;
        int         sum;
        int         act;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (pc_ready) return;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: got 0 expected 1");
    endtask

    task automatic beat(input logic [4:0] p, input logic [4:0] n,
                        input logic l);
        pc_pos   = p;
        pc_neg   = n;
        pc_last  = l;
        pc_valid = 1'b1;
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
        pc_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{5'd20, 5'd3,  10, -10,  17, 1};
        tv[1] = '{5'd31, 5'd0,  10, -10,  25, 1};
        tv[2] = '{5'd0,  5'd30, 10, -10, -25, 3};
        tv[3] = '{5'd5,  5'd5,  10, -10,   0, 0};
        tv[4] = '{5'd10, 5'd0,  10, -10,  10, 1};
        tv[5] = '{5'd0,  5'd10, 10, -10, -10, 3};
        tv[6] = '{5'd9,  5'd0,  10, -10,   9, 0};
        tv[7] = '{5'd3,  5'd0,   0,   5,   3, 1};
        tv[8] = '{5'd0,  5'd2,   0,   5,  -2, 3};
        tv[9] = '{5'd26, 5'd27, 10, -10,   0, 0};

        rst_n     = 1'b0;
        pc_pos    = '0;
        pc_neg    = '0;
        pc_last   = 1'b0;
        pc_valid  = 1'b0;
        act_ready = 1'b1;
        thr_hi    = 10'sd10;
        thr_lo    = -10'sd10;
        s_pos     = '0;
        s_neg     = '0;
        s_last    = 1'b0;
        s_valid   = 1'b0;
        s_act_ready = 1'b1;
        s_thr_hi  = 6'sd10;
        s_thr_lo  = -6'sd10;
        #12;
        chk("rst_pc_ready", int'(pc_ready), 1);
        chk("rst_act_valid", int'(act_valid), 0);
        chk("rst_act", int'(act), 0);
        chk("rst_act_sum", int'(act_sum), 0);
        chk("rst_err", int'(err_chunk), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            thr_hi = 10'(tv[i].hi);
            thr_lo = 10'(tv[i].lo);
            wait_ready();
            chk($sformatf("v%0d_pre_valid", i), int'(act_valid), 0);
            beat(tv[i].pos, tv[i].neg, 1'b1);
            chk($sformatf("v%0d_valid", i), int'(act_valid), 1);
            chk($sformatf("v%0d_sum", i), int'(act_sum), tv[i].sum);
            chk($sformatf("v%0d_act", i), int'(act), tv[i].act);
        end

        thr_hi = 10'sd10;
        thr_lo = -10'sd10;
        wait_ready();
        beat(5'd5, 5'd9, 1'b0);
        chk("t2_mid_valid", int'(act_valid), 0);
        beat(5'd2, 5'd12, 1'b0);
        beat(5'd0, 5'd7, 1'b1);
        chk("t2_valid", int'(act_valid), 1);
        chk("t2_sum", int'(act_sum), -21);
        chk("t2_act", int'(act), 3);
        chk("t2_err", int'(err_chunk), 0);

        wait_ready();
        for (int k = 0; k < 7; k++) beat(5'd25, 5'd0, 1'b0);
        chk("t4_beat7_valid", int'(act_valid), 0);
        beat(5'd25, 5'd0, 1'b0);
        chk("t4_valid", int'(act_valid), 1);
        chk("t4_sum", int'(act_sum), 200);
        chk("t4_act", int'(act), 1);
        chk("t4_err", int'(err_chunk), 1);
        wait_ready();
        beat(5'd1, 5'd0, 1'b1);
        chk("t4_next_sum", int'(act_sum), 1);
        chk("t4_err_sticky", int'(err_chunk), 1);

        wait_ready();
        act_ready = 1'b0;
        beat(5'd15, 5'd0, 1'b1);
        chk("t5_valid", int'(act_valid), 1);
        chk("t5_sum", int'(act_sum), 15);
        pc_pos   = 5'd3;
        pc_neg   = 5'd1;
        pc_last  = 1'b1;
        pc_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t5_stall%0d_ready", c), int'(pc_ready), 0);
            chk($sformatf("t5_stall%0d_valid", c), int'(act_valid), 1);
            chk($sformatf("t5_stall%0d_sum", c), int'(act_sum), 15);
            chk($sformatf("t5_stall%0d_act", c), int'(act), 1);
        end
        act_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rel_ready", int'(pc_ready), 1);
        chk("t5_rel_valid", int'(act_valid), 0);
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
        pc_last  = 1'b0;
        chk("t5_next_valid", int'(act_valid), 1);
        chk("t5_next_sum", int'(act_sum), 2);
        chk("t5_next_act", int'(act), 0);

        wait_ready();
        beat(5'd7, 5'd0, 1'b0);
        beat(5'd7, 5'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", int'(pc_ready), 1);
        chk("t6_rst_valid", int'(act_valid), 0);
        chk("t6_rst_act", int'(act), 0);
        chk("t6_rst_sum", int'(act_sum), 0);
        chk("t6_rst_err", int'(err_chunk), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(5'd10, 5'd0, 1'b1);
        chk("t6_valid", int'(act_valid), 1);
        chk("t6_sum", int'(act_sum), 10);
        chk("t6_act", int'(act), 1);

        for (int k = 0; k < 4; k++) begin
            s_pos   = 5'd25;
            s_neg   = 5'd0;
            s_last  = (k == 3);
            s_valid = 1'b1;
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        chk("w6_valid", int'(s_act_valid), 1);
`ifdef TNN_ACC_SAT_EN
        chk("w6_sum", int'(s_sum), 31);
        chk("w6_act", int'(s_act), 1);
`else
        chk("w6_sum", int'(s_sum), -28);
        chk("w6_act", int'(s_act), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
